memory_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-port, variable-latency unified memory between the core's instruction-fetch port and its load/store port. It sits between the core (PC/fetch side and byte-enable/data side) and the memory. It serializes accesses with a round-robin grant and a valid/ready handshake per requester. It also produces the `write_done` qualifier the control unit consumes, and flags hung memory accesses with a watchdog.

---
 rtl/memory_arbiter_pkg.sv | 22 ++
 rtl/memory_arbiter_if.sv | 48 ++++
 rtl/memory_arbiter.sv | 111 +++++++++++
 tb/tb_memory_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared encodings and helpers for the unified-memory arbiter
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IF = 1'b0,
    ARB_OWNER_DM = 1'b1
  } arb_owner_e;

  localparam int ARB_CNT_W = 8;

  // The watchdog counter must never wrap back below the timeout value.
  function automatic logic [ARB_CNT_W-1:0] sat_inc8(input logic [ARB_CNT_W-1:0] v);
    return (v == {ARB_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface memory_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wmask;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        write_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        bus_error;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
    input  mem_rdata, mem_ready,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready, write_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output bus_error
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
    output mem_rdata, mem_ready,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready, write_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  bus_error
  );

endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin sequencer sharing one memory between fetch and load/store
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             reset,
  memory_arbiter_if.slave bus
);

  localparam logic [ARB_CNT_W-1:0] TIMEOUT_LIMIT = ARB_CNT_W'(TIMEOUT_CYCLES);

  arb_state_e           state;
  arb_state_e           state_next;
  arb_owner_e           owner;
  arb_owner_e           last_grant;
  arb_owner_e           grant;
  logic [ARB_CNT_W-1:0] busy_cnt;
  logic [ARB_CNT_W-1:0] busy_cnt_inc;
  logic                 any_req;
  logic                 mem_hit;
  logic                 expire;

  assign any_req      = bus.if_req | bus.dm_req;
  assign grant        = (bus.dm_req && (!bus.if_req || last_grant == ARB_OWNER_IF))
                        ? ARB_OWNER_DM : ARB_OWNER_IF;
  assign busy_cnt_inc = sat_inc8(busy_cnt);
  assign mem_hit      = (state == ARB_BUSY) && bus.mem_ready;
  // A completion in the expiry cycle takes priority over the abort.
  assign expire       = (state == ARB_BUSY) && !bus.mem_ready && (busy_cnt_inc == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (any_req) state_next = ARB_BUSY;
      ARB_BUSY: if (mem_hit || expire) state_next = ARB_RESP;
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.if_ready   = (state == ARB_RESP) && (owner == ARB_OWNER_IF);
    bus.dm_ready   = (state == ARB_RESP) && (owner == ARB_OWNER_DM);
    bus.write_done = (state == ARB_RESP) && (owner == ARB_OWNER_DM) && bus.mem_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= ARB_OWNER_IF;
      last_grant    <= ARB_OWNER_IF;
      busy_cnt      <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.bus_error <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner       <= grant;
            busy_cnt    <= '0;
            bus.mem_req <= 1'b1;
            if (grant == ARB_OWNER_DM) begin
              bus.mem_we    <= bus.dm_we;
              bus.mem_addr  <= bus.dm_addr;
              bus.mem_wdata <= bus.dm_we ? bus.dm_wdata : 32'd0;
              bus.mem_wmask <= bus.dm_we ? bus.dm_wmask : 4'b0000;
            end else begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.if_addr;
              bus.mem_wdata <= 32'd0;
              bus.mem_wmask <= 4'b0000;
            end
          end
        end
        ARB_BUSY: begin
          busy_cnt <= busy_cnt_inc;
          if (mem_hit) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) begin
              if (owner == ARB_OWNER_DM) bus.dm_rdata <= bus.mem_rdata;
              else                       bus.if_rdata <= bus.mem_rdata;
            end
          end else if (expire) begin
            bus.mem_req   <= 1'b0;
            bus.bus_error <= 1'b1;
            if (owner == ARB_OWNER_DM) bus.dm_rdata <= 32'd0;
            else                       bus.if_rdata <= 32'd0;
          end
        end
        ARB_RESP: last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - transaction-level scoreboard bench for memory_arbiter
module tb_memory_arbiter;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  memory_arbiter_if bus();

  memory_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int mode = 0;  // 0: drop on ready, 1: random, 2: hold requests high

  bit          act = 0;
  bit          g_dm, g_we;
  int          g_cycle, g_lat, resp_cycle, free_cycle;
  logic [31:0] g_addr, g_wdata, g_data;
  logic [3:0]  g_wmask;
  bit          last_dm = 0;
  bit          err_exp = 0;
  bit          noise = 0;
  logic [31:0] if_rd_exp = 0, dm_rd_exp = 0;
  int          lat_q[$];
  logic [31:0] data_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
  endtask

  function automatic int eff_lat(input int l);
    return (l < T) ? l : T;
  endfunction

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm();
    bus.dm_req   = 1'b1;
    bus.dm_we    = $urandom_range(1, 0);
    bus.dm_addr  = $urandom;
    bus.dm_wdata = $urandom;
    bus.dm_wmask = 4'($urandom);
  endtask

  // One clock cycle: check this cycle's outputs, drive this cycle's inputs, advance.
  task automatic step();
    bit exp_if, exp_dm, in_busy, done_now;
    done_now = act && (cyc == resp_cycle);
    exp_if   = done_now && !g_dm;
    exp_dm   = done_now && g_dm;
    if (done_now) begin
      if (g_lat > T) begin
        err_exp = 1;
        if (g_dm) dm_rd_exp = 0; else if_rd_exp = 0;
      end else if (!g_we) begin
        if (g_dm) dm_rd_exp = g_data; else if_rd_exp = g_data;
      end
    end
    in_busy = act && (cyc > g_cycle) && (cyc <= g_cycle + eff_lat(g_lat));

    chk("if_ready", bus.if_ready, exp_if);
    chk("dm_ready", bus.dm_ready, exp_dm);
    chk("write_done", bus.write_done, exp_dm && g_we);
    chk("ready_exclusive", bus.if_ready & bus.dm_ready, 0);
    chk("mem_req", bus.mem_req, in_busy);
    chk("bus_error", bus.bus_error, err_exp);
    if (exp_if) chk("if_rdata", bus.if_rdata, if_rd_exp);
    if (exp_dm) chk("dm_rdata", bus.dm_rdata, dm_rd_exp);
    if (in_busy) begin
      chk("mem_addr", bus.mem_addr, g_addr);
      chk("mem_we", bus.mem_we, g_we);
      chk("mem_wmask", bus.mem_wmask, g_we ? g_wmask : 4'b0000);
      if (g_we) chk("mem_wdata", bus.mem_wdata, g_wdata);
    end
    if (done_now) act = 0;

    if (exp_if) begin
      if (mode == 0 || (mode == 1 && $urandom_range(1, 0) == 0)) bus.if_req = 1'b0;
      else if (mode == 1) new_if();
    end else if (mode == 1 && !bus.if_req && $urandom_range(2, 0) == 0) new_if();
    if (exp_dm) begin
      if (mode == 0 || (mode == 1 && $urandom_range(1, 0) == 0)) bus.dm_req = 1'b0;
      else if (mode == 1) new_dm();
    end else if (mode == 1 && !bus.dm_req && $urandom_range(2, 0) == 0) new_dm();

    if (!act && cyc >= free_cycle && (bus.if_req || bus.dm_req)) begin
      g_dm    = bus.dm_req && (!bus.if_req || !last_dm);
      last_dm = g_dm;
      act     = 1;
      g_cycle = cyc;
      g_lat   = (lat_q.size() > 0) ? lat_q.pop_front() : $urandom_range(6, 1);
      g_data  = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
      if (g_dm) begin
        g_we = bus.dm_we; g_addr = bus.dm_addr; g_wdata = bus.dm_wdata; g_wmask = bus.dm_wmask;
      end else begin
        g_we = 0; g_addr = bus.if_addr; g_wdata = 0; g_wmask = 0;
      end
      resp_cycle = cyc + eff_lat(g_lat) + 1;
      free_cycle = resp_cycle + 1;
    end

    if (in_busy) begin
      bus.mem_ready = (cyc == g_cycle + g_lat);
      bus.mem_rdata = g_data;
    end else begin
      bus.mem_ready = (mode == 1) ? 1'($urandom_range(1, 0)) : noise;
      bus.mem_rdata = $urandom;
    end
    noise = 0;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    act = 0; last_dm = 0; err_exp = 0; if_rd_exp = 0; dm_rd_exp = 0;
    free_cycle = cyc;
    lat_q.delete();
    data_q.delete();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wmask", bus.mem_wmask, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_dm_ready", bus.dm_ready, 0);
    chk("rst_write_done", bus.write_done, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_bus_error", bus.bus_error, 0);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_quiet(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (!act && !bus.if_req && !bus.dm_req) begin
        ok = 1;
        break;
      end
      step();
    end
    chk("quiet_within_budget", ok, 1);
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_wmask = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    apply_reset();

    // Zero-wait fetch.
    lat_q.push_back(1);
    data_q.push_back(32'h0050_0093);
    bus.if_req = 1; bus.if_addr = 32'h100;
    run_quiet(20);

    // Store with three wait states; completion coincides with watchdog expiry.
    lat_q.push_back(4);
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h204;
    bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_wmask = 4'b1111;
    run_quiet(20);

    // Both ports held high: grants alternate starting with data.
    apply_reset();
    mode = 2;
    for (int i = 0; i < 6; i++) lat_q.push_back(1);
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h80;
    run_n(16);
    mode = 0;
    run_quiet(30);

    // Memory never answers: watchdog abort, sticky bus_error.
    lat_q.push_back(255);
    bus.if_req = 1; bus.if_addr = 32'h300;
    run_quiet(20);
    lat_q.push_back(2);
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h400;
    run_quiet(20);

    // Reset in the second busy cycle of a load, then a stray mem_ready.
    apply_reset();
    lat_q.push_back(3);
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h500;
    for (int i = 0; i < 10; i++) begin
      if (act && cyc == g_cycle + 2) break;
      step();
    end
    apply_reset();
    noise = 1;
    run_n(3);
    lat_q.push_back(2);
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h504;
    run_quiet(20);

    // Randomized traffic, latencies on both sides of the timeout.
    for (int r = 0; r < 5; r++) begin
      mode = 1;
      run_n(300);
      mode = 0;
      run_quiet(100);
      apply_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
